rst_sequencer: RTL and testbench
================================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: cycles btn_n must be stable low to count as a press (10 ms at 50 MHz).
REQ-002 SHALL have parameter MMCM_RST_CYCLES, default 16: width of the mmcm_rst pulse in cycles.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 5000000: cycles to wait for lock before retrying.
REQ-004 SHALL have parameter POST_LOCK_CYCLES, default 256: cycles lock must hold before core reset is released.
REQ-005 SHALL have port clk, input, 1: board oscillator clock (clk50M domain), the MMCM input clock.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port btn_n, input, 1: raw push-button, active-low, asynchronous.
REQ-008 SHALL have port ext_rst, input, 1: raw external reset pin, active-high, asynchronous.
REQ-009 SHALL have port mmcm_locked, input, 1: MMCM LOCKED, asynchronous.
REQ-010 SHALL have port mmcm_rst, output, 1: MMCM RST drive.
REQ-011 SHALL have port core_rst_n, output, 1: active-low reset to fpga_core; the core domain re-synchronises it.
REQ-012 SHALL have port state, output, 2: current FSM state encoding.
REQ-013 SHALL have port retry_cnt, output, 4: lock-timeout retry count, saturating.

Function
REQ-014 SHALL synchronise btn_n, ext_rst and mmcm_locked through 2-flop synchronisers each; all decisions SHALL use the synchronised values.
REQ-015 SHALL assert a debounced press when synchronised btn_n has been low for DEBOUNCE_CYCLES consecutive cycles; any high sample SHALL clear the debounce counter; the press level SHALL stay asserted while btn_n stays low.
REQ-016 SHALL define restart_req = debounced press OR synchronised ext_rst.
REQ-017 SHALL implement FSM states MMCM_RST=0, WAIT_LOCK=1, HOLD=2, RUN=3, with one shared cycle counter.
REQ-018 MMCM_RST: mmcm_rst=1, core_rst_n=0; the counter SHALL be held at 0 while restart_req=1; otherwise it increments; after MMCM_RST_CYCLES counted cycles the FSM SHALL go to WAIT_LOCK and the counter SHALL clear.
REQ-019 WAIT_LOCK: mmcm_rst=0, core_rst_n=0; locked_sync=1 SHALL go to HOLD with the counter cleared; the counter reaching LOCK_TIMEOUT-1 without lock SHALL go to MMCM_RST and increment retry_cnt, saturating at 15.
REQ-020 HOLD: mmcm_rst=0, core_rst_n=0; locked_sync=0 SHALL go to MMCM_RST; after POST_LOCK_CYCLES counted cycles the FSM SHALL go to RUN.
REQ-021 RUN: mmcm_rst=0, core_rst_n=1; locked_sync=0 SHALL go to MMCM_RST.
REQ-022 restart_req=1 in WAIT_LOCK, HOLD or RUN SHALL go to MMCM_RST on the next edge, and SHALL take priority over every other transition in the same cycle.
REQ-023 mmcm_rst and core_rst_n SHALL be registered outputs decoded from the next state, so they change in the same edge as state.
REQ-024 core_rst_n SHALL fall in the same cycle the FSM leaves RUN; it SHALL never be 1 while mmcm_rst=1.
REQ-025 retry_cnt SHALL clear only on rst, and SHALL NOT clear on a restart.
REQ-026 Counter width SHALL be $clog2 of the largest of MMCM_RST_CYCLES, LOCK_TIMEOUT and POST_LOCK_CYCLES, plus 1, and SHALL NOT wrap within any state.

Reset
REQ-027 On rst=1: state=MMCM_RST, mmcm_rst=1, core_rst_n=0, retry_cnt=0, all counters and synchroniser flops 0 (the btn_n synchroniser SHALL reset to 1).
REQ-028 rst SHALL assert asynchronously; after its release the sequence SHALL start from MMCM_RST with a full MMCM_RST_CYCLES pulse.

Structure
REQ-029 State encodings and the retry saturation value SHALL live in shared package rst_pkg.
REQ-030 The 2-flop synchroniser SHALL be one sub-module, sync2, instantiated three times with a reset-value parameter.

Verification (DEBOUNCE_CYCLES=8, MMCM_RST_CYCLES=4, LOCK_TIMEOUT=32, POST_LOCK_CYCLES=16)
REQ-031 Release rst; raise mmcm_locked 10 cycles later -> mmcm_rst high for exactly 4 cycles, state walks 0→1→2→3, core_rst_n rises exactly 16 cycles after HOLD entry.
REQ-032 Hold mmcm_locked=0 -> mmcm_rst re-pulses every 4+32 cycles; retry_cnt counts 1,2,…,15 and stays at 15.
REQ-033 In RUN, pulse btn_n low for 5 cycles -> no restart; hold it low for 20 cycles -> core_rst_n falls 2+8 cycles after the fall and mmcm_rst stays high until btn_n rises, then for 4 more cycles.
REQ-034 In HOLD, drop mmcm_locked for 1 cycle -> state=MMCM_RST and core_rst_n is never 1.
REQ-035 Assert ext_rst and drop mmcm_locked in the same cycle during RUN -> a single MMCM_RST entry; retry_cnt unchanged.
REQ-036 Assert rst mid-HOLD -> outputs return to their reset values immediately (no clock edge needed) and retry_cnt=0.

Source files
------------

// File: rtl/rst_pkg.sv
// Shared encodings for the board reset sequencer: FSM state codes,
// retry counter width/saturation value and a small sizing helper.
package rst_pkg;

  localparam logic [1:0] ST_MMCM_RST  = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam int              RETRY_W   = 4;
  localparam logic [RETRY_W-1:0] RETRY_MAX = 4'd15;

  // Largest of three cycle counts; sizes the shared FSM counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/rst_sequencer_sync2.sv
// Two-flop synchroniser with a configurable reset level, so idle-high
// inputs (active-low button) do not look asserted straight out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/rst_sequencer.sv
// Board reset sequencer: pulses the MMCM reset, waits for lock (with
// retry on timeout), requires lock to hold for a while, then releases
// the core reset. Button presses and the external pin restart the
// sequence. The state output exposes the FSM for observation.
module rst_sequencer
  import rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int MMCM_RST_CYCLES  = 16,
  parameter int LOCK_TIMEOUT     = 5000000,
  parameter int POST_LOCK_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_n,
  input  logic               ext_rst,
  input  logic               mmcm_locked,
  output logic               mmcm_rst,
  output logic               core_rst_n,
  output logic [1:0]         state,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int CNT_W = $clog2(max3(MMCM_RST_CYCLES, LOCK_TIMEOUT, POST_LOCK_CYCLES)) + 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [CNT_W-1:0] MR_LAST = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PL_LAST = CNT_W'(POST_LOCK_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic w_btn_sync;
  logic w_ext_sync;
  logic w_locked_sync;
  logic w_press;
  logic w_restart_req;

  logic [DB_W-1:0]    r_db_cnt;
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic               r_mmcm_rst;
  logic               r_core_rst_n;

  logic [1:0]         w_next_state;
  logic [CNT_W-1:0]   w_next_cnt;
  logic               w_retry_inc;

  sync2 #(.RST_VAL(1'b1)) u_sync_btn (.clk(clk), .rst(rst), .d(btn_n),       .q(w_btn_sync));
  sync2 #(.RST_VAL(1'b0)) u_sync_ext (.clk(clk), .rst(rst), .d(ext_rst),     .q(w_ext_sync));
  sync2 #(.RST_VAL(1'b0)) u_sync_lck (.clk(clk), .rst(rst), .d(mmcm_locked), .q(w_locked_sync));

  // Debounce: count consecutive low samples, saturating one short of the
  // threshold; the press is the threshold-th consecutive low sample and
  // stays asserted while the button remains low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt <= '0;
    end else if (w_btn_sync) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt != DB_LAST) begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_press       = !w_btn_sync && (r_db_cnt == DB_LAST);
  assign w_restart_req = w_press || w_ext_sync;

  // Next-state and shared-counter decode; restart wins over everything.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt + CNT_W'(1);
    w_retry_inc  = 1'b0;
    case (r_state)
      ST_MMCM_RST: begin
        if (w_restart_req) begin
          w_next_cnt = '0;
        end else if (r_cnt == MR_LAST) begin
          w_next_state = ST_WAIT_LOCK;
          w_next_cnt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_restart_req) begin
          w_next_state = ST_MMCM_RST;
          w_next_cnt   = '0;
        end else if (w_locked_sync) begin
          w_next_state = ST_HOLD;
          w_next_cnt   = '0;
        end else if (r_cnt == LT_LAST) begin
          w_next_state = ST_MMCM_RST;
          w_next_cnt   = '0;
          w_retry_inc  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_restart_req || !w_locked_sync) begin
          w_next_state = ST_MMCM_RST;
          w_next_cnt   = '0;
        end else if (r_cnt == PL_LAST) begin
          w_next_state = ST_RUN;
          w_next_cnt   = '0;
        end
      end
      ST_RUN: begin
        // Counter parked at zero in RUN so it never wraps.
        w_next_cnt = '0;
        if (w_restart_req || !w_locked_sync) begin
          w_next_state = ST_MMCM_RST;
        end
      end
      default: begin
        w_next_state = ST_MMCM_RST;
        w_next_cnt   = '0;
      end
    endcase
  end

  // State, counter and outputs decoded from the next state so they move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_MMCM_RST;
      r_cnt        <= '0;
      r_mmcm_rst   <= 1'b1;
      r_core_rst_n <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_mmcm_rst   <= (w_next_state == ST_MMCM_RST);
      r_core_rst_n <= (w_next_state == ST_RUN);
    end
  end

  // Lock-timeout retry count; survives restarts, saturates at the max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retry <= '0;
    end else if (w_retry_inc && (r_retry != RETRY_MAX)) begin
      r_retry <= r_retry + RETRY_W'(1);
    end
  end

  assign mmcm_rst   = r_mmcm_rst;
  assign core_rst_n = r_core_rst_n;
  assign state      = r_state;
  assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with small timing parameters.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_n;
  logic       ext_rst;
  logic       mmcm_locked;
  logic       mmcm_rst;
  logic       core_rst_n;
  logic [1:0] state;
  logic [3:0] retry_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic overlap_seen = 1'b0;

  typedef struct {
    logic       btn_n;
    logic       ext_rst;
    logic       locked;
    int         steps;
    logic [1:0] st;
    logic       mm;
    logic       core;
    logic [3:0] retry;
  } vec_t;

  vec_t vecs[30];

  rst_sequencer #(
    .DEBOUNCE_CYCLES (8),
    .MMCM_RST_CYCLES (4),
    .LOCK_TIMEOUT    (32),
    .POST_LOCK_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .ext_rst    (ext_rst),
    .mmcm_locked(mmcm_locked),
    .mmcm_rst   (mmcm_rst),
    .core_rst_n (core_rst_n),
    .state      (state),
    .retry_cnt  (retry_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Safety monitor: core must never be out of reset while the MMCM is held.
  always @(negedge clk) begin
    if (!rst && mmcm_rst && core_rst_n) overlap_seen = 1'b1;
  end

  function automatic vec_t mk(input logic b, input logic e, input logic l, input int n,
                              input logic [1:0] s, input logic m, input logic c,
                              input logic [3:0] r);
    vec_t v;
    v.btn_n = b; v.ext_rst = e; v.locked = l; v.steps = n;
    v.st = s; v.mm = m; v.core = c; v.retry = r;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [1:0] est, input logic emm,
                       input logic ecore, input logic [3:0] eret);
    n_tests++;
    if (state !== est || mmcm_rst !== emm || core_rst_n !== ecore || retry_cnt !== eret) begin
      n_fail++;
      $display("FAIL %s: got state=%0d mmcm_rst=%b core_rst_n=%b retry=%0d, want state=%0d mmcm_rst=%b core_rst_n=%b retry=%0d",
               nm, state, mmcm_rst, core_rst_n, retry_cnt, est, emm, ecore, eret);
    end
  endtask

  initial begin
    // btn, ext, lock, steps -> state, mmcm_rst, core_rst_n, retry
    // Bring-up: lock raised 10 cycles after reset release.
    vecs[0]  = mk(1, 0, 0,  0, 0, 1, 0, 0);
    vecs[1]  = mk(1, 0, 0,  3, 0, 1, 0, 0);
    vecs[2]  = mk(1, 0, 0,  1, 1, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0,  6, 1, 0, 0, 0);
    vecs[4]  = mk(1, 0, 1,  2, 1, 0, 0, 0);
    vecs[5]  = mk(1, 0, 1,  1, 2, 0, 0, 0);
    vecs[6]  = mk(1, 0, 1, 15, 2, 0, 0, 0);
    vecs[7]  = mk(1, 0, 1,  1, 3, 0, 1, 0);
    // Short 5-cycle press: ignored.
    vecs[8]  = mk(0, 0, 1,  5, 3, 0, 1, 0);
    vecs[9]  = mk(1, 0, 1, 10, 3, 0, 1, 0);
    // Long 20-cycle press: core reset falls 10 cycles after the fall.
    vecs[10] = mk(0, 0, 1,  9, 3, 0, 1, 0);
    vecs[11] = mk(0, 0, 1,  1, 0, 1, 0, 0);
    vecs[12] = mk(0, 0, 1, 10, 0, 1, 0, 0);
    // Release: 2 sync cycles then 4 counted MMCM reset cycles.
    vecs[13] = mk(1, 0, 1,  5, 0, 1, 0, 0);
    vecs[14] = mk(1, 0, 1,  1, 1, 0, 0, 0);
    vecs[15] = mk(1, 0, 1,  1, 2, 0, 0, 0);
    // One-cycle lock drop in HOLD.
    vecs[16] = mk(1, 0, 0,  1, 2, 0, 0, 0);
    vecs[17] = mk(1, 0, 1,  1, 2, 0, 0, 0);
    vecs[18] = mk(1, 0, 1,  1, 0, 1, 0, 0);
    vecs[19] = mk(1, 0, 1,  3, 0, 1, 0, 0);
    vecs[20] = mk(1, 0, 1,  1, 1, 0, 0, 0);
    vecs[21] = mk(1, 0, 1,  1, 2, 0, 0, 0);
    vecs[22] = mk(1, 0, 1, 15, 2, 0, 0, 0);
    vecs[23] = mk(1, 0, 1,  1, 3, 0, 1, 0);
    // ext_rst and lock loss together in RUN: one restart, no retry.
    vecs[24] = mk(1, 1, 0,  2, 3, 0, 1, 0);
    vecs[25] = mk(1, 1, 0,  1, 0, 1, 0, 0);
    vecs[26] = mk(1, 0, 0,  5, 0, 1, 0, 0);
    vecs[27] = mk(1, 0, 0,  1, 1, 0, 0, 0);
    // No lock: first timeout after 32 WAIT_LOCK cycles.
    vecs[28] = mk(1, 0, 0, 31, 1, 0, 0, 0);
    vecs[29] = mk(1, 0, 0,  1, 0, 1, 0, 1);

    // Reset block
    rst = 1'b1; btn_n = 1'b1; ext_rst = 1'b0; mmcm_locked = 1'b0;
    step(3);
    check("reset_state", 2'd0, 1'b1, 1'b0, 4'd0);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      btn_n       = vecs[i].btn_n;
      ext_rst     = vecs[i].ext_rst;
      mmcm_locked = vecs[i].locked;
      step(vecs[i].steps);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].mm, vecs[i].core, vecs[i].retry);
    end

    // Repeated timeouts: 4-cycle pulse then 32 cycles waiting, retry saturates.
    for (int r = 1; r <= 15; r++) begin
      step(3);
      check($sformatf("retry_pulse_%0d", r), 2'd0, 1'b1, 1'b0, 4'(r));
      step(1);
      check($sformatf("retry_wait_%0d", r), 2'd1, 1'b0, 1'b0, 4'(r));
      step(32);
      check($sformatf("retry_next_%0d", r), 2'd0, 1'b1, 1'b0, (r < 15) ? 4'(r + 1) : 4'd15);
    end

    // Reach HOLD, then assert rst between edges.
    mmcm_locked = 1'b1;
    step(3);
    check("hold_pre_mr", 2'd0, 1'b1, 1'b0, 4'd15);
    step(1);
    check("hold_pre_wl", 2'd1, 1'b0, 1'b0, 4'd15);
    step(1);
    check("hold_entry", 2'd2, 1'b0, 1'b0, 4'd15);
    step(5);
    check("hold_mid", 2'd2, 1'b0, 1'b0, 4'd15);
    #3 rst = 1'b1;
    #1;
    check("async_rst", 2'd0, 1'b1, 1'b0, 4'd0);
    #2 rst = 1'b0;
    step(3);
    check("post_rst_pulse", 2'd0, 1'b1, 1'b0, 4'd0);
    step(1);
    check("post_rst_wl", 2'd1, 1'b0, 1'b0, 4'd0);
    step(1);
    check("post_rst_hold", 2'd2, 1'b0, 1'b0, 4'd0);

    n_tests++;
    if (overlap_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL no_overlap: core_rst_n was 1 while mmcm_rst was 1 (got %b, want 0)", overlap_seen);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
